// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, FSM states and
// ALU operation selects.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b101,
    OP_SUB   = 3'b110,
    OP_HALT  = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MEM,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10
  } alu_sel_e;

endpackage

// File: rtl/controller_mc_if.sv
// Instruction handshake plus datapath/memory control bus of controller_mc.
// master = controller side, slave = instruction source / datapath side.
interface controller_mc_if #(
  parameter int IW  = 12,
  parameter int RAW = 3,
  parameter int DAW = 4
) ();

  logic           instr_valid;
  logic [IW-1:0]  instr;
  logic           instr_ready;
  logic           D_rd;
  logic           D_wr;
  logic           isExternal;
  logic           wr_en;
  logic [1:0]     ALUSel;
  logic [DAW-1:0] D_addr;
  logic [RAW-1:0] RF_addr1;
  logic [RAW-1:0] RF_addr2;
  logic [RAW-1:0] RF_waddr;

  modport master (
    input  instr_valid, instr,
    output instr_ready, D_rd, D_wr, isExternal, wr_en, ALUSel,
           D_addr, RF_addr1, RF_addr2, RF_waddr
  );

  modport slave (
    output instr_valid, instr,
    input  instr_ready, D_rd, D_wr, isExternal, wr_en, ALUSel,
           D_addr, RF_addr1, RF_addr2, RF_waddr
  );

endinterface

// File: rtl/instr_decode.sv
// Purely combinational instruction decoder: opcode class flags, ALU select
// and operand field extraction.
module instr_decode
  import cpu_pkg::*;
#(
  parameter int IW  = 12,
  parameter int RAW = 3,
  parameter int DAW = 4
) (
  input  logic [IW-1:0]  instr_i,
  output logic           is_load_o,
  output logic           is_store_o,
  output logic           is_alu_o,
  output logic           is_halt_o,
  output logic           is_illegal_o,
  output alu_sel_e       alu_sel_o,
  output logic [RAW-1:0] mem_reg_o,
  output logic [DAW-1:0] mem_addr_o,
  output logic [RAW-1:0] dst_o,
  output logic [RAW-1:0] src_b_o,
  output logic [RAW-1:0] src_a_o
);

  opcode_e opcode;

  assign opcode     = opcode_e'(instr_i[IW-1:IW-3]);
  assign mem_reg_o  = instr_i[RAW+3:4];
  assign mem_addr_o = instr_i[DAW-1:0];
  assign dst_o      = instr_i[3*RAW-1:2*RAW];
  assign src_b_o    = instr_i[2*RAW-1:RAW];
  assign src_a_o    = instr_i[RAW-1:0];

  // Classify the opcode; unlisted encodings fall through to illegal.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    is_load_o    = 1'b0;
    is_store_o   = 1'b0;
    is_alu_o     = 1'b0;
    is_halt_o    = 1'b0;
    is_illegal_o = 1'b0;
    alu_sel_o    = ALU_PASS;
    case (opcode)
      OP_LOAD:  is_load_o  = 1'b1;
      OP_STORE: is_store_o = 1'b1;
      OP_ADD: begin
        is_alu_o  = 1'b1;
        alu_sel_o = ALU_ADD;
      end
      OP_SUB: begin
        is_alu_o  = 1'b1;
        alu_sel_o = ALU_SUB;
      end
      OP_HALT:  is_halt_o    = 1'b1;
      default:  is_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/controller_mc.sv
// Multi-cycle CPU controller: fetches one instruction per go pulse (step) or
// continuously once armed (run), sequencing memory/ALU/RF strobes.
module controller_mc
  import cpu_pkg::*;
#(
  parameter int IW   = 12,
  parameter int RAW  = 3,
  parameter int DAW  = 4,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mode,
  input  logic            go,
  controller_mc_if.master bus,
  output logic            busy,
  output logic            halted,
  output logic            illegal,
  output logic [CNTW-1:0] retired
);

  state_e          state_q, state_d;
  logic            armed_q, armed_d;
  logic [IW-1:0]   instr_q, instr_d;
  logic            illegal_q, illegal_d;
  logic [CNTW-1:0] retired_q, retired_d;

  // Registered output copies.
  logic            ready_q, ready_d;
  logic            d_rd_q, d_rd_d;
  logic            d_wr_q, d_wr_d;
  logic            ext_q, ext_d;
  logic            wr_en_q, wr_en_d;
  alu_sel_e        alu_q, alu_d;
  logic [DAW-1:0]  d_addr_q, d_addr_d;
  logic [RAW-1:0]  rf1_q, rf1_d;
  logic [RAW-1:0]  rf2_q, rf2_d;
  logic [RAW-1:0]  rfw_q, rfw_d;
  logic            busy_q, busy_d;
  logic            halted_q, halted_d;

  logic            done;
  logic [IW-1:0]   dec_in;
  logic            dec_load, dec_store, dec_alu, dec_halt, dec_illegal;
  alu_sel_e        dec_alu_sel;
  logic [RAW-1:0]  dec_reg, dec_dst, dec_src_b, dec_src_a;
  logic [DAW-1:0]  dec_addr;

  // In FETCH the offered word is decoded so the next state's outputs can be
  // registered in the accept cycle; afterwards the latched copy is used.
  assign dec_in = (state_q == S_FETCH) ? bus.instr : instr_q;

  instr_decode #(.IW(IW), .RAW(RAW), .DAW(DAW)) u_decode (
    .instr_i      (dec_in),
    .is_load_o    (dec_load),
    .is_store_o   (dec_store),
    .is_alu_o     (dec_alu),
    .is_halt_o    (dec_halt),
    .is_illegal_o (dec_illegal),
    .alu_sel_o    (dec_alu_sel),
    .mem_reg_o    (dec_reg),
    .mem_addr_o   (dec_addr),
    .dst_o        (dec_dst),
    .src_b_o      (dec_src_b),
    .src_a_o      (dec_src_a)
  );

  // Next-state, run arming, retire counting and next output values.
  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    instr_d   = instr_q;
    illegal_d = illegal_q;
    retired_d = retired_q;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!mode) begin
          armed_d = 1'b0;
          if (go) state_d = S_FETCH;
        end else if (go || armed_q) begin
          armed_d = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          if (dec_illegal) begin
            illegal_d = 1'b1;
            armed_d   = armed_q & mode;
            state_d   = S_IDLE;
          end else if (dec_halt) begin
            state_d = S_HALT;
          end else if (dec_load) begin
            state_d = S_MEM;
          end else if (dec_store || dec_alu) begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC:  state_d = dec_store ? S_MEM : S_WB;
      S_MEM: begin
        if (dec_store) done = 1'b1;
        else           state_d = S_WB;
      end
      S_WB:    done = 1'b1;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // Instruction boundary: retire, then continue only if still in run mode.
    if (done) begin
      retired_d = retired_q + CNTW'(1);
      state_d   = (mode && armed_q) ? S_FETCH : S_IDLE;
      if (!mode) armed_d = 1'b0;
    end

    ready_d  = 1'b0;
    d_rd_d   = 1'b0;
    d_wr_d   = 1'b0;
    ext_d    = 1'b0;
    wr_en_d  = 1'b0;
    alu_d    = ALU_PASS;
    d_addr_d = '0;
    rf1_d    = '0;
    rf2_d    = '0;
    rfw_d    = '0;
    busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d = (state_d == S_HALT);

    case (state_d)
      S_FETCH: ready_d = 1'b1;
      S_EXEC: begin
        if (dec_store) begin
          rf1_d    = dec_reg;
          d_addr_d = dec_addr;
        end else begin
          rf1_d = dec_src_a;
          rf2_d = dec_src_b;
          alu_d = dec_alu_sel;
        end
      end
      S_MEM: begin
        d_addr_d = dec_addr;
        if (dec_store) begin
          d_wr_d = 1'b1;
          rf1_d  = dec_reg;
        end else begin
          d_rd_d = 1'b1;
          ext_d  = 1'b1;
        end
      end
      S_WB: begin
        wr_en_d = 1'b1;
        if (dec_load) begin
          rfw_d = dec_reg;
        end else begin
          rfw_d = dec_dst;
          rf1_d = dec_src_a;
          rf2_d = dec_src_b;
          alu_d = dec_alu_sel;
        end
      end
      default: ;
    endcase
  end

  // State and output registers; asynchronous reset clears everything.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (!reset) begin
      state_q   <= S_IDLE;
      armed_q   <= 1'b0;
      instr_q   <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
      ready_q   <= 1'b0;
      d_rd_q    <= 1'b0;
      d_wr_q    <= 1'b0;
      ext_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      alu_q     <= ALU_PASS;
      d_addr_q  <= '0;
      rf1_q     <= '0;
      rf2_q     <= '0;
      rfw_q     <= '0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      instr_q   <= instr_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
      ready_q   <= ready_d;
      d_rd_q    <= d_rd_d;
      d_wr_q    <= d_wr_d;
      ext_q     <= ext_d;
      wr_en_q   <= wr_en_d;
      alu_q     <= alu_d;
      d_addr_q  <= d_addr_d;
      rf1_q     <= rf1_d;
      rf2_q     <= rf2_d;
      rfw_q     <= rfw_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.D_rd        = d_rd_q;
  assign bus.D_wr        = d_wr_q;
  assign bus.isExternal  = ext_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.ALUSel      = alu_q;
  assign bus.D_addr      = d_addr_q;
  assign bus.RF_addr1    = rf1_q;
  assign bus.RF_addr2    = rf2_q;
  assign bus.RF_waddr    = rfw_q;
  assign busy            = busy_q;
  assign halted          = halted_q;
  assign illegal         = illegal_q;
  assign retired         = retired_q;

endmodule
